// File: rtl/sm_div_pkg.sv
// Shared types for the sign-magnitude divider and its reconstruction unit.
// Sign sits directly above the magnitude in every operand.
package sm_div_pkg;

   localparam int MAG_W = 4;
   localparam int ACC_W = 2*MAG_W + 1;
   localparam int CNT_W = $clog2(MAG_W);

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm5_t;

   typedef struct packed {
      logic             sign;
      logic [MAG_W:0]   mag;
   } sm6_t;

   typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

endpackage

// File: rtl/sm_shift_add_step.sv
// One shift-add multiplier step: adds the divisor magnitude, shifted by the
// current bit position, when the selected quotient bit is set.
module sm_shift_add_step
   import sm_div_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic [MAG_W-1:0] bmag,
   input  logic [CNT_W-1:0] cnt,
   input  logic             q_bit,
   output logic [ACC_W-1:0] acc_next
);

   logic [ACC_W-1:0] shifted [MAG_W];

   genvar gi;
   generate
      for (gi = 0; gi < MAG_W; gi++) begin : g_shift
         assign shifted[gi] = ACC_W'(bmag) << gi;
      end
   endgenerate

   assign acc_next = acc + (q_bit ? shifted[cnt] : '0);

endmodule

// File: rtl/sm_div_reconstruct.sv
// Rebuilds the dividend A = Q*B + R from divider outputs with a 4-cycle
// shift-add multiply, flagging magnitude overflow and quotient sign mismatch.
module sm_div_reconstruct
   import sm_div_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MAG_W:0] Q,
   input  logic [MAG_W:0] B,
   input  logic [MAG_W+1:0] R,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [MAG_W:0] A,
   output logic           ovf,
   output logic           sign_err
);

   state_t           state_reg, state_next;
   sm5_t             q_reg, b_reg, a_reg;
   sm6_t             r_reg;
   logic [ACC_W-1:0] acc_reg, acc_step, acc_sum;
   logic [CNT_W-1:0] cnt_reg;
   logic             ovf_reg, sign_err_reg, out_valid_reg;
   logic             sign_err_next;
   logic             last_step;

   sm_shift_add_step u_step (
      .acc      (acc_reg),
      .bmag     (b_reg.mag),
      .cnt      (cnt_reg),
      .q_bit    (q_reg.mag[cnt_reg]),
      .acc_next (acc_step)
   );

   assign last_step = (cnt_reg == CNT_W'(MAG_W-1));
   assign acc_sum   = acc_reg + ACC_W'(r_reg.mag);

   // A zero divisor leaves the quotient sign undefined, so only Q==0 is legal;
   // 5'b10000 is a nonzero divisor and follows the normal sign rule.
   assign sign_err_next = (b_reg == '0) ? (q_reg != '0)
                                        : (q_reg.sign ^ r_reg.sign ^ b_reg.sign);

   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (in_valid)  state_next = MUL;
         MUL:  if (last_step) state_next = ADD;
         ADD:                 state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = out_valid_reg;
      A         = a_reg;
      ovf       = ovf_reg;
      sign_err  = sign_err_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_reg         <= '0;
         b_reg         <= '0;
         r_reg         <= '0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         a_reg         <= '0;
         ovf_reg       <= 1'b0;
         sign_err_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  q_reg   <= Q;
                  b_reg   <= B;
                  r_reg   <= R;
                  acc_reg <= '0;
                  cnt_reg <= '0;
               end
            end
            MUL: begin
               acc_reg <= acc_step;
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
            ADD: begin
               acc_reg       <= acc_sum;
               a_reg         <= {r_reg.sign, acc_sum[MAG_W-1:0]};
               ovf_reg       <= |acc_sum[ACC_W-1:MAG_W];
               sign_err_reg  <= sign_err_next;
               out_valid_reg <= 1'b1;
            end
            DONE: begin
               if (out_ready) out_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_div_reconstruct.sv
// Directed and randomized checks of sm_div_reconstruct against an arithmetic
// model of A = Q*B + R with overflow and sign-consistency flags.
module tb_sm_div_reconstruct;
   import sm_div_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [4:0] Q = '0;
   logic [4:0] B = '0;
   logic [5:0] R = '0;
   logic       in_ready, out_valid, ovf, sign_err;
   logic [4:0] A;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sm_div_reconstruct dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Q         (Q),
      .B         (B),
      .R         (R),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .ovf       (ovf),
      .sign_err  (sign_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {A[4:0], ovf, sign_err} from plain integer arithmetic.
   function automatic logic [6:0] ref_model(input logic [4:0] q, input logic [4:0] b,
                                            input logic [5:0] r);
      int   total;
      logic se;
      total = int'(q[3:0]) * int'(b[3:0]) + int'(r[4:0]);
      if (b == 5'b00000) se = (q != 5'b00000);
      else               se = q[4] ^ r[5] ^ b[4];
      return {r[5], 4'(total), (total > 15), se};
   endfunction

   task automatic run_txn(input string tag, input logic [4:0] q, input logic [4:0] b,
                          input logic [5:0] r, input logic [6:0] exp, input int hold);
      int         k;
      logic [4:0] a_seen;
      check({tag, ":in_ready_idle"}, in_ready, 1);
      Q = q; B = b; R = r; in_valid = 1'b1;
      @(posedge clk); #1;
      // Garbage with in_valid still high must be ignored while busy.
      Q = 5'($urandom); B = 5'($urandom); R = 6'($urandom);
      check({tag, ":in_ready_busy"}, in_ready, 0);
      k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      in_valid = 1'b0;
      check({tag, ":latency"}, k, 5);
      check({tag, ":A"}, A, exp[6:2]);
      check({tag, ":ovf"}, ovf, exp[1]);
      check({tag, ":sign_err"}, sign_err, exp[0]);
      a_seen = A;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ":hold_A"}, A, a_seen);
         check({tag, ":hold_valid"}, out_valid, 1);
         check({tag, ":hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":valid_cleared"}, out_valid, 0);
      check({tag, ":in_ready_after"}, in_ready, 1);
      $display("txn %s Q=%b B=%b R=%b -> A=%b ovf=%b sign_err=%b", tag, q, b, r, a_seen, ovf, sign_err);
   endtask

   initial begin
      logic [4:0] rq, rb;
      logic [5:0] rr;
      int         seen_valid;

      repeat (2) @(posedge clk);
      #1;
      check("reset:in_ready", in_ready, 1);
      check("reset:out_valid", out_valid, 0);
      check("reset:A", A, 0);
      check("reset:ovf", ovf, 0);
      check("reset:sign_err", sign_err, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_txn("pos",       5'b00011, 5'b00100, 6'b000001, {5'b01101, 1'b0, 1'b0}, 0);
      run_txn("neg",       5'b10011, 5'b00100, 6'b100001, {5'b11101, 1'b0, 1'b0}, 0);
      run_txn("div0_ok",   5'b00000, 5'b00000, 6'b100111, {5'b10111, 1'b0, 1'b0}, 0);
      run_txn("div0_err",  5'b00001, 5'b00000, 6'b100111, {5'b10111, 1'b0, 1'b1}, 0);
      run_txn("overflow",  5'b01111, 5'b01111, 6'b000000, {5'b00001, 1'b1, 1'b0}, 0);
      run_txn("sign_mis",  5'b00011, 5'b00100, 6'b100001, {5'b11101, 1'b0, 1'b1}, 0);
      run_txn("neg_zero_b",5'b00101, 5'b10000, 6'b000011, {5'b00011, 1'b0, 1'b1}, 0);
      run_txn("backpress", 5'b00010, 5'b00101, 6'b000011, {5'b01101, 1'b0, 1'b0}, 3);

      // Reset while MUL holds cnt==2: transaction must vanish.
      Q = 5'b01111; B = 5'b01111; R = 6'b011111; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst:out_valid", out_valid, 0);
      check("midrst:in_ready", in_ready, 1);
      check("midrst:A", A, 0);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid++;
      end
      check("midrst:no_result", seen_valid, 0);
      $display("txn midrst dropped, out_valid pulses after reset=%0d", seen_valid);

      for (int n = 0; n < 40; n++) begin
         rq = 5'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 1) << 4) : 5'($urandom);
         rr = 6'($urandom);
         run_txn($sformatf("rnd%0d", n), rq, rb, rr, ref_model(rq, rb, rr), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
